// File: rtl/fp_writeback_arbiter.sv
// Float register file writeback arbiter.
// Round-robin arbitration gives the single write port to NREQ writeback sources.
// Writes reach the register file one cycle after the request is consumed.
// A pending-write scoreboard is kept alongside for the decode stage's RAW stall check.

// Per-requester decode: legality check and the scoreboard bits this write retires.
module fp_wb_lane_dec #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_reg,
  input  logic          i_dbl,
  output logic          o_illegal,
  output logic [31:0]   o_clr
);
  logic w_top;

  assign w_top     = (i_reg == AW'(31));
  // f0 is hardwired, and a double at f31 would need f32, which does not exist.
  assign o_illegal = (i_reg == '0) | (i_dbl & w_top);

  // Clear mask: reg, plus reg+1 for a double; reg+1 is never formed past f31.
  always_comb begin
    o_clr = 32'(1) << i_reg;
    if (i_dbl && !w_top) o_clr = o_clr | (32'(1) << (i_reg + AW'(1)));
  end
endmodule

module fp_writeback_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_reg,
  input  logic [NREQ*DW-1:0]   req_data1,
  input  logic [NREQ*DW-1:0]   req_data2,
  input  logic [NREQ-1:0]      req_double,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_reg,
  input  logic                 issue_double,
  output logic                 issue_stall,
  output logic [31:0]          pend_mask,
  output logic [AW-1:0]        writeRegf,
  output logic [DW-1:0]        writeData1f,
  output logic [DW-1:0]        writeData2f,
  output logic                 regWritef,
  output logic                 regDWritef,
  output logic                 err_illegal
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic [AW-1:0] rg;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          dbl;
    logic          ill;
  } wb_req_t;

  logic [PW-1:0]              r_ptr;
  logic [31:0]                r_pend;
  logic [AW-1:0]              r_wreg;
  logic [DW-1:0]              r_d1;
  logic [DW-1:0]              r_d2;
  logic                       r_we;
  logic                       r_dwe;
  logic                       r_err;

  logic [NREQ-1:0]            w_gnt;
  logic [PW-1:0]              w_gidx;
  logic                       w_fire;
  logic [NREQ-1:0]            w_ill;
  logic [NREQ-1:0][31:0]      w_clr;
  wb_req_t                    w_sel;
  logic [31:0]                w_sel_clr;
  logic                       w_iss_top;
  logic                       w_iss_nxt;
  logic [31:0]                w_set;
  logic [31:0]                w_pend_nxt;

  // One decoder per requester, so the grant path never waits on data decode.
  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    fp_wb_lane_dec #(.AW(AW)) u_dec (
      .i_reg     (req_reg[g*AW +: AW]),
      .i_dbl     (req_double[g]),
      .o_illegal (w_ill[g]),
      .o_clr     (w_clr[g])
    );
  end

  // Round-robin search from r_ptr; nothing is granted while reset is held.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    found  = 1'b0;
    idx    = '0;
    w_gnt  = '0;
    w_gidx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(r_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        w_gnt[idx]  = 1'b1;
        w_gidx      = idx;
      end
    end
    if (reset) w_gnt = '0;
  end

  assign req_ready = w_gnt;
  assign w_fire    = |w_gnt;

  // One-hot mux of the granted request and its scoreboard clear mask.
  always_comb begin
    w_sel     = '0;
    w_sel_clr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel.rg  = req_reg[i*AW +: AW];
        w_sel.d1  = req_data1[i*DW +: DW];
        w_sel.d2  = req_data2[i*DW +: DW];
        w_sel.dbl = req_double[i];
        w_sel.ill = w_ill[i];
        w_sel_clr = w_clr[i];
      end
    end
  end

  // RAW hazard: the issued destination (or its pair) still has a write in flight.
  assign w_iss_top   = (issue_reg == AW'(31));
  assign w_iss_nxt   = issue_double & ~w_iss_top & r_pend[issue_reg + AW'(1)];
  assign issue_stall = issue_valid & (r_pend[issue_reg] | w_iss_nxt);

  // Scoreboard set for an accepted issue; writes to f0 are never tracked.
  always_comb begin
    w_set = '0;
    if (issue_valid && !issue_stall && issue_reg != '0) begin
      w_set = 32'(1) << issue_reg;
      if (issue_double && !w_iss_top) w_set = w_set | (32'(1) << (issue_reg + AW'(1)));
    end
  end

  // Clear before set so a newer producer issued this cycle keeps its bit.
  assign w_pend_nxt = ((r_pend & ~(w_fire ? w_sel_clr : 32'h0)) | w_set) & ~32'h1;

  // Write port register, scoreboard and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr  <= '0;
      r_pend <= '0;
      r_wreg <= '0;
      r_d1   <= '0;
      r_d2   <= '0;
      r_we   <= 1'b0;
      r_dwe  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_we   <= w_fire & ~w_sel.ill & ~w_sel.dbl;
      r_dwe  <= w_fire & ~w_sel.ill & w_sel.dbl;
      r_err  <= w_fire & w_sel.ill;
      if (w_fire) begin
        r_wreg <= w_sel.rg;
        r_d1   <= w_sel.d1;
        r_d2   <= w_sel.d2;
        r_ptr  <= (w_gidx == PW'(NREQ-1)) ? '0 : w_gidx + PW'(1);
      end
    end
  end

  assign pend_mask   = r_pend;
  assign writeRegf   = r_wreg;
  assign writeData1f = r_d1;
  assign writeData2f = r_d2;
  assign regWritef   = r_we;
  assign regDWritef  = r_dwe;
  assign err_illegal = r_err;
endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// Directed bench for fp_writeback_arbiter: grant order, write port timing,
// illegal-write handling, scoreboard set/clear/stall and reset behaviour.
module tb_fp_writeback_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_reg;
  logic [NREQ*DW-1:0]   req_data1;
  logic [NREQ*DW-1:0]   req_data2;
  logic [NREQ-1:0]      req_double;
  logic                 issue_valid;
  logic [AW-1:0]        issue_reg;
  logic                 issue_double;
  logic                 issue_stall;
  logic [31:0]          pend_mask;
  logic [AW-1:0]        writeRegf;
  logic [DW-1:0]        writeData1f;
  logic [DW-1:0]        writeData2f;
  logic                 regWritef;
  logic                 regDWritef;
  logic                 err_illegal;

  int n_chk  = 0;
  int n_fail = 0;

  fp_writeback_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_reg      (req_reg),
    .req_data1    (req_data1),
    .req_data2    (req_data2),
    .req_double   (req_double),
    .issue_valid  (issue_valid),
    .issue_reg    (issue_reg),
    .issue_double (issue_double),
    .issue_stall  (issue_stall),
    .pend_mask    (pend_mask),
    .writeRegf    (writeRegf),
    .writeData1f  (writeData1f),
    .writeData2f  (writeData2f),
    .regWritef    (regWritef),
    .regDWritef   (regDWritef),
    .err_illegal  (err_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rg, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input logic dbl);
    req_reg[i*AW +: AW]   = rg;
    req_data1[i*DW +: DW] = d1;
    req_data2[i*DW +: DW] = d2;
    req_double[i]         = dbl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_reg = '0; req_data1 = '0; req_data2 = '0;
    req_double = '0; issue_valid = 1'b0; issue_reg = '0; issue_double = 1'b0;
    tick();
    // A valid request while reset is held must not be granted.
    req_valid = 3'b001;
    #1 chk("ready_in_reset", 64'(req_ready), 64'h0);
    tick();
    req_valid = '0;
    chk("rst_we", 64'(regWritef), 64'h0);
    chk("rst_dwe", 64'(regDWritef), 64'h0);
    chk("rst_err", 64'(err_illegal), 64'h0);
    chk("rst_pend", 64'(pend_mask), 64'h0);
    chk("rst_wreg", 64'(writeRegf), 64'h0);
    chk("rst_d1", 64'(writeData1f), 64'h0);
    reset = 1'b0;

    // Test 1: single write, one-cycle latency, one-cycle strobe.
    set_req(0, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0);
    req_valid = 3'b001;
    #1 chk("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    chk("t1_we", 64'(regWritef), 64'h1);
    chk("t1_dwe", 64'(regDWritef), 64'h0);
    chk("t1_wreg", 64'(writeRegf), 64'd5);
    chk("t1_d1", 64'(writeData1f), 64'hDEADBEEF);
    tick();
    chk("t1_we_drop", 64'(regWritef), 64'h0);

    // Test 2: all three contend; grants rotate 0,1,2,0,1,2 from a fresh pointer.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), DW'(32'h1000 + i), 32'h0, 1'b0);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1 chk("t2_ready", 64'(req_ready), 64'(1 << (k % 3)));
      tick();
      chk("t2_wreg", 64'(writeRegf), 64'(10 + k % 3));
      chk("t2_we", 64'(regWritef), 64'h1);
      chk("t2_d1", 64'(writeData1f), 64'(32'h1000 + k % 3));
    end
    req_valid = '0;

    // Test 3: double issue sets a pair, overlapping issue stalls, double write clears.
    issue_valid = 1'b1; issue_reg = 5'd8; issue_double = 1'b1;
    #1 chk("t3_nostall", 64'(issue_stall), 64'h0);
    tick();
    chk("t3_pend_set", 64'(pend_mask), 64'h300);
    issue_reg = 5'd9; issue_double = 1'b0;
    #1 chk("t3_stall", 64'(issue_stall), 64'h1);
    tick();
    issue_valid = 1'b0;
    chk("t3_pend_hold", 64'(pend_mask), 64'h300);
    set_req(1, 5'd8, 32'hA1A1A1A1, 32'hB2B2B2B2, 1'b1);
    req_valid = 3'b010;
    #1 chk("t3_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    chk("t3_pend_clr", 64'(pend_mask), 64'h0);
    chk("t3_dwe", 64'(regDWritef), 64'h1);
    chk("t3_we", 64'(regWritef), 64'h0);
    chk("t3_wreg", 64'(writeRegf), 64'd8);
    chk("t3_d1", 64'(writeData1f), 64'hA1A1A1A1);
    chk("t3_d2", 64'(writeData2f), 64'hB2B2B2B2);

    // Test 4: double at f31 only marks f31; f0 is never tracked; illegal writes dropped.
    issue_valid = 1'b1; issue_reg = 5'd31; issue_double = 1'b1;
    #1 chk("t4_nostall", 64'(issue_stall), 64'h0);
    tick();
    chk("t4_pend31", 64'(pend_mask), 64'h80000000);
    issue_reg = 5'd0; issue_double = 1'b0;
    tick();
    issue_valid = 1'b0;
    chk("t4_pend_f0", 64'(pend_mask), 64'h80000000);
    set_req(2, 5'd31, 32'h31, 32'h32, 1'b1);
    set_req(0, 5'd0, 32'h00, 32'h0, 1'b0);
    req_valid = 3'b101;
    #1 chk("t4_ready2", 64'(req_ready), 64'h4);
    tick();
    req_valid = 3'b001;
    chk("t4_err_a", 64'(err_illegal), 64'h1);
    chk("t4_we_a", 64'(regWritef), 64'h0);
    chk("t4_dwe_a", 64'(regDWritef), 64'h0);
    chk("t4_pend_clr", 64'(pend_mask), 64'h0);
    #1 chk("t4_ready0", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    chk("t4_err_b", 64'(err_illegal), 64'h1);
    chk("t4_we_b", 64'(regWritef), 64'h0);
    chk("t4_dwe_b", 64'(regDWritef), 64'h0);
    tick();
    chk("t4_err_drop", 64'(err_illegal), 64'h0);

    // Test 5: issue f4 while a write to f4 retires; the newer producer keeps the bit.
    set_req(1, 5'd4, 32'h44, 32'h0, 1'b0);
    req_valid = 3'b010;
    issue_valid = 1'b1; issue_reg = 5'd4; issue_double = 1'b0;
    #1 chk("t5_nostall", 64'(issue_stall), 64'h0);
    chk("t5_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0; issue_valid = 1'b0;
    chk("t5_pend", 64'(pend_mask), 64'h10);
    chk("t5_we", 64'(regWritef), 64'h1);
    chk("t5_wreg", 64'(writeRegf), 64'd4);

    // Test 6: reset right after a grant drops the write, clears state and the pointer.
    set_req(2, 5'd12, 32'h77, 32'h0, 1'b0);
    req_valid = 3'b100;
    #1 chk("t6_ready", 64'(req_ready), 64'h4);
    tick();
    chk("t6_we_pre", 64'(regWritef), 64'h1);
    reset = 1'b1;
    set_req(0, 5'd20, 32'h20, 32'h0, 1'b0);
    set_req(1, 5'd21, 32'h21, 32'h0, 1'b0);
    req_valid = 3'b011;
    #1 chk("t6_ready_rst", 64'(req_ready), 64'h0);
    tick();
    reset = 1'b0;
    chk("t6_we_post", 64'(regWritef), 64'h0);
    chk("t6_pend", 64'(pend_mask), 64'h0);
    chk("t6_wreg", 64'(writeRegf), 64'h0);
    #1 chk("t6_ready_ptr0", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    chk("t6_we_next", 64'(regWritef), 64'h1);
    chk("t6_wreg_next", 64'(writeRegf), 64'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
